// File: rtl/burst_ram_responder.sv
// burst_ram_responder: block-RAM backed responder for the 4-beat x 64-bit
// burst RAM interface. Models calibration delay, read latency and the minimum
// command interval. Raises a sticky flag when an initiator breaks the protocol.
module burst_ram_responder #(
  parameter int ADDRESS_BITWIDTH       = 21,
  parameter int STORAGE_DEPTH_BITWIDTH = 10,
  parameter int READ_LATENCY           = 8,
  parameter int COMMAND_INTERVAL       = 14,
  parameter int INIT_CYCLES            = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        init_calib,
  input  logic                        cmd,
  input  logic                        cmd_en,
  input  logic [ADDRESS_BITWIDTH-1:0] addr,
  input  logic [63:0]                 wr_data,
  input  logic [7:0]                  data_mask,
  output logic [63:0]                 rd_data,
  output logic                        rd_data_valid,
  output logic                        cmd_error
);

  localparam int N      = STORAGE_DEPTH_BITWIDTH;
  localparam int DEPTH  = 1 << N;
  localparam int INIT_W = $clog2(INIT_CYCLES + 2);
  localparam int IVL_W  = $clog2(COMMAND_INTERVAL + 1);
  localparam int PH_W   = $clog2(READ_LATENCY + 4);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BEATS = 2'd1,
    RD_WAIT  = 2'd2,
    RD_BEATS = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [PH_W-1:0]     phase_reg, phase_next;   // cycles left in current state
  logic [1:0]          beat_reg, beat_next;     // next beat offset within the wrap group
  logic [N-1:0]        base_reg, base_next;     // burst start word index
  logic [IVL_W-1:0]    ivl_reg;                 // command interval countdown
  logic [INIT_W-1:0]   init_cnt_reg;            // calibration countdown
  logic                init_calib_reg;
  logic                cmd_error_reg;
  logic                rd_valid_reg;
  logic [63:0]         rd_data_reg;

  logic                accept;
  logic [N-1:0]        addr_word;
  logic [1:0]          wrap_lo;
  logic [N-1:0]        beat_idx;
  logic                wr_en;
  logic [N-1:0]        wr_idx;
  logic [N-1:0]        rd_idx;
  logic [63:0]         ram_q;
  logic                unused_addr_bits;

  // Byte offset and aliased upper bits are intentionally dropped.
  assign unused_addr_bits = ^addr;

  assign addr_word = addr[N+2:3];
  assign wrap_lo   = base_reg[1:0] + beat_reg;
  assign beat_idx  = {base_reg[N-1:2], wrap_lo};
  assign accept    = cmd_en && init_calib_reg && (state_reg == IDLE) && (ivl_reg == '0);

  // Next-state, burst bookkeeping and RAM port control.
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    beat_next  = beat_reg;
    base_next  = base_reg;
    wr_en      = 1'b0;
    wr_idx     = beat_idx;
    rd_idx     = beat_idx;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          base_next = addr_word;
          if (cmd) begin
            // Beat 0 of a write lands in the accept cycle itself.
            wr_en      = 1'b1;
            wr_idx     = addr_word;
            state_next = WR_BEATS;
            phase_next = PH_W'(2);
            beat_next  = 2'd1;
          end else begin
            state_next = RD_WAIT;
            phase_next = PH_W'(READ_LATENCY - 2);
            beat_next  = 2'd0;
          end
        end
      end
      WR_BEATS: begin
        wr_en      = 1'b1;
        beat_next  = beat_reg + 2'd1;
        phase_next = phase_reg - PH_W'(1);
        if (phase_reg == '0) state_next = IDLE;
      end
      RD_WAIT: begin
        phase_next = phase_reg - PH_W'(1);
        if (phase_reg == '0) begin
          // Last wait cycle prefetches beat 0 so it is ready one cycle later.
          state_next = RD_BEATS;
          phase_next = PH_W'(3);
          beat_next  = beat_reg + 2'd1;
        end
      end
      RD_BEATS: begin
        beat_next  = beat_reg + 2'd1;
        phase_next = phase_reg - PH_W'(1);
        if (phase_reg == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM and burst bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      beat_reg  <= '0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      beat_reg  <= beat_next;
      base_reg  <= base_next;
    end
  end

  // Calibration delay, command spacing and sticky protocol-error tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_reg   <= INIT_W'(INIT_CYCLES);
      init_calib_reg <= 1'b0;
      ivl_reg        <= '0;
      cmd_error_reg  <= 1'b0;
    end else begin
      if (init_cnt_reg != '0) init_cnt_reg <= init_cnt_reg - INIT_W'(1);
      init_calib_reg <= init_calib_reg | (init_cnt_reg == '0);
      if (accept)               ivl_reg <= IVL_W'(COMMAND_INTERVAL - 1);
      else if (ivl_reg != '0)   ivl_reg <= ivl_reg - IVL_W'(1);
      cmd_error_reg <= cmd_error_reg | (cmd_en & ~accept);
    end
  end

  // Registered read outputs; data holds the last beat once valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= (state_reg == RD_BEATS);
      if (state_reg == RD_BEATS) rd_data_reg <= ram_q;
    end
  end

  // One byte-wide block RAM per lane so the mask maps to lane write enables.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] lane_q_reg;

      // Lane write with byte mask and synchronous read; contents survive reset.
      always_ff @(posedge clk) begin
        if (wr_en && !data_mask[gi]) mem[wr_idx] <= wr_data[gi*8 +: 8];
        lane_q_reg <= mem[rd_idx];
      end

      assign ram_q[gi*8 +: 8] = lane_q_reg;
    end
  endgenerate

  assign init_calib    = init_calib_reg;
  assign cmd_error     = cmd_error_reg;
  assign rd_data       = rd_data_reg;
  assign rd_data_valid = rd_valid_reg;

endmodule

// File: tb/tb_burst_ram_responder.sv
// Directed self-checking bench for burst_ram_responder.
module tb_burst_ram_responder;

  logic        clk;
  logic        rst_n;
  logic        init_calib;
  logic        cmd;
  logic        cmd_en;
  logic [20:0] addr;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        cmd_error;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] DF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DM = 64'hFFFF_FFFF_1111_1111;

  burst_ram_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .init_calib    (init_calib),
    .cmd           (cmd),
    .cmd_en        (cmd_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .data_mask     (data_mask),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .cmd_error     (cmd_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One active edge, then return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    cmd_en = 1'b0;
    #1;
    check_value({tag, "_rst_valid"}, 64'(rd_data_valid), 64'd0);
    check_value({tag, "_rst_data"},  rd_data,             64'd0);
    check_value({tag, "_rst_calib"}, 64'(init_calib),    64'd0);
    check_value({tag, "_rst_err"},   64'(cmd_error),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40 && !init_calib; i++) tick();
    check_value({tag, "_init_wait"}, 64'(init_calib), 64'd1);
    $display("reset %s: done, init_calib=%0b", tag, init_calib);
  endtask

  // Write burst: beat 0 on the accept edge, beats 1..3 on following edges;
  // takes 14 edges total so the next command meets the interval.
  task automatic write_burst(input logic [20:0] a,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3,
                             input logic [7:0]  m0);
    cmd = 1'b1; cmd_en = 1'b1; addr = a; wr_data = d0; data_mask = m0;
    tick();
    cmd_en = 1'b0; wr_data = d1; data_mask = 8'h00;
    tick();
    wr_data = d2;
    tick();
    wr_data = d3;
    tick();
    wr_data = '0;
    for (int k = 4; k < 14; k++) tick();
    $display("write addr=%h beats=%h %h %h %h mask0=%h", a, d0, d1, d2, d3, m0);
  endtask

  // Read burst: records valid beats over 13 edges after accept; optionally
  // injects a second cmd_en at edge viol_at (0 = none).
  task automatic read_burst(input string tag, input logic [20:0] a,
                            input logic [63:0] e0, input logic [63:0] e1,
                            input logic [63:0] e2, input logic [63:0] e3,
                            input int viol_at, input logic exp_err);
    logic [63:0] got [4];
    logic [63:0] exp [4];
    int nvalid = 0;
    int first  = -1;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int i = 0; i < 4; i++) got[i] = '0;
    cmd = 1'b0; cmd_en = 1'b1; addr = a;
    tick();
    cmd_en = 1'b0;
    for (int k = 1; k < 14; k++) begin
      cmd_en = (k == viol_at);
      tick();
      if (rd_data_valid) begin
        if (nvalid == 0) first = k;
        if (nvalid < 4) got[nvalid] = rd_data;
        nvalid++;
      end
    end
    cmd_en = 1'b0;
    check_value({tag, "_first_valid"}, 64'(first),  64'd8);
    check_value({tag, "_nvalid"},      64'(nvalid), 64'd4);
    for (int i = 0; i < 4; i++)
      check_value($sformatf("%s_beat%0d", tag, i), got[i], exp[i]);
    check_value({tag, "_cmd_error"}, 64'(cmd_error), 64'(exp_err));
    $display("read %s addr=%h first=%0d beats=%0d data=%h %h %h %h err=%0b",
             tag, a, first, nvalid, got[0], got[1], got[2], got[3], cmd_error);
  endtask

  initial begin
    rst_n = 1'b1; cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = '0; data_mask = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_value("reset_valid", 64'(rd_data_valid), 64'd0);
    check_value("reset_data",  rd_data,             64'd0);
    check_value("reset_calib", 64'(init_calib),    64'd0);
    check_value("reset_err",   64'(cmd_error),     64'd0);

    // Early command at cycle 5 must be rejected; calibration at cycle 17.
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    check_value("early_err_before", 64'(cmd_error), 64'd0);
    cmd = 1'b0; cmd_en = 1'b1; addr = 21'h0;
    tick();
    cmd_en = 1'b0;
    check_value("early_err_after", 64'(cmd_error), 64'd1);
    for (int k = 6; k <= 16; k++) tick();
    check_value("calib_at_16", 64'(init_calib), 64'd0);
    tick();
    check_value("calib_at_17", 64'(init_calib), 64'd1);
    check_value("early_no_read", 64'(rd_data_valid), 64'd0);
    $display("init: calib rose at cycle 17, early cmd err=%0b", cmd_error);

    do_reset("clear");

    write_burst(21'h000040, D1, D2, D3, D4, 8'h00);
    read_burst("aligned", 21'h000040, D1, D2, D3, D4, 0, 1'b0);
    read_burst("wrap",    21'h000050, D3, D4, D1, D2, 0, 1'b0);

    write_burst(21'h000040, DF, D2, D3, D4, 8'h0F);
    read_burst("mask",    21'h000040, DM, D2, D3, D4, 0, 1'b0);

    read_burst("interval", 21'h000040, DM, D2, D3, D4, 10, 1'b1);

    // Reset during beat 2 of a read: valid must drop without a clock edge.
    cmd = 1'b0; cmd_en = 1'b1; addr = 21'h000040;
    tick();
    cmd_en = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    check_value("midrd_valid", 64'(rd_data_valid), 64'd1);
    check_value("midrd_beat2", rd_data,             D3);
    #2;
    do_reset("midread");

    read_burst("alias", 21'h002040, DM, D2, D3, D4, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
